// File: rtl/sipo_pkg.sv
// ---------------------------------------------------------------------------
// sipo_pkg
// Shared constants, types and helper functions for the SIPO deserializer.
//
// Optional feature macro: SIPO_PARITY_EN
//   When defined, each serial frame carries WIDTH data bits followed by one
//   even-parity bit, so frames are WIDTH+1 bits long.
// ---------------------------------------------------------------------------
package sipo_pkg;

  localparam int unsigned WIDTH_DEFAULT     = 4;
  localparam bit          MSB_FIRST_DEFAULT = 1'b1;

  // Counter width for the default build. It is wide enough for 0..WIDTH,
  // which also covers the extra parity position.
  localparam int unsigned CNT_W = $clog2(WIDTH_DEFAULT + 1);

  typedef logic [CNT_W-1:0] cnt_t;

`ifdef SIPO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Serial bits per frame for the default width.
  localparam int unsigned FRAME_LEN = WIDTH_DEFAULT + (PARITY_EN ? 1 : 0);

  // Serial bits per frame for an arbitrary word width.
  function automatic int unsigned frame_len(input int unsigned width);
    return PARITY_EN ? width + 1 : width;
  endfunction

  // Bit counter width for an arbitrary word width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// ---------------------------------------------------------------------------
// sipo_shift_core
// Holds the shift register, the serial bit counter and (with SIPO_PARITY_EN)
// the running parity. It reports when the current bit completes a frame and
// presents the assembled word combinationally, so the top level can capture
// the word on the same edge that accepts the final bit.
//
// Optional feature macro: SIPO_PARITY_EN (adds word_perr output)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   flush      in   discard the partially assembled frame
//   bit_en     in   a serial bit is accepted this cycle
//   bit_in     in   the serial bit
//   last_bit   out  counter sits on the final bit position of the frame
//   word_done  out  the accepted bit completes the frame
//   word       out  assembled word (valid while word_done is high)
//   word_perr  out  parity error of the completed frame (SIPO_PARITY_EN)
// ---------------------------------------------------------------------------
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEFAULT,
  parameter bit          MSB_FIRST = MSB_FIRST_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             bit_en,
  input  logic             bit_in,
  output logic             last_bit,
  output logic             word_done,
`ifdef SIPO_PARITY_EN
  output logic             word_perr,
`endif
  output logic [WIDTH-1:0] word
);

  localparam int unsigned   CW       = cnt_width(WIDTH);
  localparam int unsigned   FLEN     = frame_len(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(FLEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] shifted;
`ifdef SIPO_PARITY_EN
  logic             par_q, par_d;
`endif

  // The new bit enters at the LSB end and walks up for MSB-first order, or
  // enters at the MSB end and walks down for LSB-first order. Either way the
  // first bit of the frame ends up in its final position after WIDTH shifts.
  always_comb begin
    if (MSB_FIRST) begin
      shifted = {shreg_q[WIDTH-2:0], bit_in};
    end else begin
      shifted = {bit_in, shreg_q[WIDTH-1:1]};
    end
  end

  assign last_bit  = (cnt_q == LAST_CNT);
  assign word_done = bit_en && last_bit;

`ifdef SIPO_PARITY_EN
  // The final bit is the parity bit: the data is already complete in the
  // shift register and the parity bit only contributes to the error flag.
  assign word      = shreg_q;
  assign word_perr = par_q ^ bit_in;
`else
  // The final bit is a data bit, so the word includes it.
  assign word = shifted;
`endif

  // Flush wins over any bit; a completed frame restarts the counter.
  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
`ifdef SIPO_PARITY_EN
    par_d   = par_q;
`endif
    if (flush || word_done) begin
      cnt_d   = '0;
      shreg_d = '0;
`ifdef SIPO_PARITY_EN
      par_d   = 1'b0;
`endif
    end else if (bit_en) begin
      cnt_d   = cnt_q + CNT_ONE;
      shreg_d = shifted;
`ifdef SIPO_PARITY_EN
      par_d   = par_q ^ bit_in;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      shreg_q <= '0;
`ifdef SIPO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
`ifdef SIPO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// ---------------------------------------------------------------------------
// sipo_deserializer
// Serial-in / parallel-out deserializer with valid/ready handshakes on both
// sides. WIDTH serial bits are assembled into a word that is held in an
// output register until the downstream stage accepts it. Only the final bit
// of a frame can stall, and only when the held word has not been consumed.
//
// Optional feature macro: SIPO_PARITY_EN
//   Frames carry a trailing even-parity bit and p_perr reports its check.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   flush    in   synchronous discard of the partially assembled word
//   s_data   in   serial data bit
//   s_valid  in   s_data valid
//   s_ready  out  a serial bit can be accepted this cycle
//   p_data   out  assembled word
//   p_valid  out  p_data holds an unconsumed word
//   p_ready  in   downstream accepts p_data this cycle
//   p_perr   out  parity error for p_data (SIPO_PARITY_EN only)
// ---------------------------------------------------------------------------
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEFAULT,
  parameter bit          MSB_FIRST = MSB_FIRST_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] p_data,
  output logic             p_valid,
`ifdef SIPO_PARITY_EN
  output logic             p_perr,
`endif
  input  logic             p_ready
);

  logic             out_free;
  logic             accept;
  logic             last_bit;
  logic             word_done;
  logic [WIDTH-1:0] core_word;
  logic [WIDTH-1:0] p_data_q, p_data_d;
  logic             p_valid_q, p_valid_d;
`ifdef SIPO_PARITY_EN
  logic             core_perr;
  logic             p_perr_q, p_perr_d;
`endif

  // The output register can take a new word if it is empty or being drained
  // on this very edge, which is what lets words stream without bubbles.
  assign out_free = !p_valid_q || p_ready;
  assign s_ready  = !flush && (!last_bit || out_free);
  assign accept   = s_valid && s_ready;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bit_en    (accept),
    .bit_in    (s_data),
    .last_bit  (last_bit),
    .word_done (word_done),
`ifdef SIPO_PARITY_EN
    .word_perr (core_perr),
`endif
    .word      (core_word)
  );

  // A freshly completed word takes priority over the consume, so p_valid
  // stays high when one word leaves and the next arrives on the same edge.
  always_comb begin
    p_data_d  = p_data_q;
    p_valid_d = p_valid_q;
`ifdef SIPO_PARITY_EN
    p_perr_d  = p_perr_q;
`endif
    if (word_done) begin
      p_data_d  = core_word;
      p_valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
      p_perr_d  = core_perr;
`endif
    end else if (p_ready) begin
      p_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_data_q  <= '0;
      p_valid_q <= 1'b0;
`ifdef SIPO_PARITY_EN
      p_perr_q  <= 1'b0;
`endif
    end else begin
      p_data_q  <= p_data_d;
      p_valid_q <= p_valid_d;
`ifdef SIPO_PARITY_EN
      p_perr_q  <= p_perr_d;
`endif
    end
  end

  assign p_data  = p_data_q;
  assign p_valid = p_valid_q;
`ifdef SIPO_PARITY_EN
  assign p_perr  = p_perr_q;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// ---------------------------------------------------------------------------
// tb_sipo_deserializer
// Drives an MSB-first and an LSB-first deserializer with identical inputs.
// A frame-level model collects accepted bits in a queue, and when a frame is
// complete it pushes the expected word for both bit orders into a scoreboard.
// An independent monitor compares whatever the DUTs present against it.
// ---------------------------------------------------------------------------
module tb_sipo_deserializer;

  localparam int W = 4;
`ifdef SIPO_PARITY_EN
  localparam int FLEN = W + 1;
`else
  localparam int FLEN = W;
`endif

  typedef struct {
    logic [W-1:0] d_msb;
    logic [W-1:0] d_lsb;
    logic         perr;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         s_data;
  logic         s_valid;
  logic         p_ready;
  logic         s_ready_m, s_ready_l;
  logic [W-1:0] p_data_m, p_data_l;
  logic         p_valid_m, p_valid_l;
`ifdef SIPO_PARITY_EN
  logic         p_perr_m, p_perr_l;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  logic m_bits[$];
  logic m_held = 1'b0;
  exp_t exp_q[$];
  logic [W-1:0] seen_msb[$];
  logic exp_accept = 1'b0;
  logic exp_pop    = 1'b0;
  logic exp_flush  = 1'b0;
  logic exp_bit    = 1'b0;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready_m),
    .p_data  (p_data_m),
    .p_valid (p_valid_m),
`ifdef SIPO_PARITY_EN
    .p_perr  (p_perr_m),
`endif
    .p_ready (p_ready)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready_l),
    .p_data  (p_data_l),
    .p_valid (p_valid_l),
`ifdef SIPO_PARITY_EN
    .p_perr  (p_perr_l),
`endif
    .p_ready (p_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive after the falling edge, then check the
  // combinational ready against the model and record what the model expects
  // to happen on the coming rising edge.
  task automatic applyStimulus(input logic v, input logic d, input logic pr,
                               input logic fl, output logic acc);
    logic exp_ready;
    @(negedge clk);
    s_valid = v;
    s_data  = d;
    p_ready = pr;
    flush   = fl;
    #1;
    exp_ready = !fl && ((m_bits.size() != FLEN - 1) || !m_held || pr);
    checkOutput("s_ready_msb", int'(s_ready_m), int'(exp_ready));
    checkOutput("s_ready_lsb", int'(s_ready_l), int'(exp_ready));
    exp_accept = v && exp_ready;
    exp_pop    = m_held && pr;
    exp_flush  = fl;
    exp_bit    = d;
    acc        = exp_accept;
  endtask

  // Sends seq[n-1] first, retrying each bit until accepted (bounded).
  task automatic sendSeq(input logic [7:0] seq, input int n, input logic pr);
    logic acc;
    for (int i = 0; i < n; i++) begin
      int tries = 0;
      do begin
        applyStimulus(1'b1, seq[n-1-i], pr, 1'b0, acc);
        tries++;
      end while (!acc && tries < 50);
      if (!acc) checkOutput("send_timeout", 0, 1);
    end
  endtask

  // Sends one data word; with parity frames a correct even-parity bit follows.
  task automatic sendWord(input logic [W-1:0] w, input logic pr);
`ifdef SIPO_PARITY_EN
    sendSeq({3'b000, w, ^w}, FLEN, pr);
`else
    sendSeq({4'b0000, w}, FLEN, pr);
`endif
  endtask

  task automatic idle(input int cycles, input logic pr);
    logic acc;
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, pr, 1'b0, acc);
  endtask

  task automatic clearModel();
    m_bits.delete();
    exp_q.delete();
    m_held     = 1'b0;
    exp_accept = 1'b0;
    exp_pop    = 1'b0;
    exp_flush  = 1'b0;
  endtask

  // Frame-level model: collect accepted bits, build both bit orders when
  // a frame is complete.
  always @(posedge clk) begin
    logic done;
    exp_t e;
    done = 1'b0;
    if (!rst) begin
      m_bits.delete();
      m_held = 1'b0;
    end else begin
      if (exp_flush) begin
        m_bits.delete();
      end else if (exp_accept) begin
        m_bits.push_back(exp_bit);
        if (m_bits.size() == FLEN) begin
          e.perr = 1'b0;
          for (int i = 0; i < W; i++) begin
            e.d_msb[W-1-i] = m_bits[i];
            e.d_lsb[i]     = m_bits[i];
          end
          for (int i = 0; i < FLEN; i++) e.perr = e.perr ^ m_bits[i];
          exp_q.push_back(e);
          m_bits.delete();
          done = 1'b1;
        end
      end
      if (done) m_held = 1'b1;
      else if (exp_pop) m_held = 1'b0;
    end
  end

  // Monitor: compares the parallel side against the scoreboard every cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        checkOutput("p_valid_msb", int'(p_valid_m), int'(m_held));
        checkOutput("p_valid_lsb", int'(p_valid_l), int'(m_held));
        if (m_held) begin
          if (exp_q.size() == 0) begin
            checkOutput("scoreboard_empty", 1, 0);
          end else begin
            checkOutput("p_data_msb", int'(p_data_m), int'(exp_q[0].d_msb));
            checkOutput("p_data_lsb", int'(p_data_l), int'(exp_q[0].d_lsb));
`ifdef SIPO_PARITY_EN
            checkOutput("p_perr_msb", int'(p_perr_m), int'(exp_q[0].perr));
            checkOutput("p_perr_lsb", int'(p_perr_l), int'(exp_q[0].perr));
`endif
            if (p_ready) begin
              seen_msb.push_back(p_data_m);
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    logic acc;
    rst     = 1'b0;
    flush   = 1'b0;
    s_data  = 1'b0;
    s_valid = 1'b0;
    p_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_p_valid", int'(p_valid_m), 0);
    checkOutput("reset_p_data", int'(p_data_m), 0);
    checkOutput("reset_p_data_lsb", int'(p_data_l), 0);
    @(negedge clk);
    rst = 1'b1;
    idle(1, 1'b1);
    checkOutput("ready_after_reset", int'(s_ready_m), 1);

    // Basic word 1,0,1,1
`ifdef SIPO_PARITY_EN
    sendSeq(8'b0001_0111, FLEN, 1'b1);
`else
    sendSeq(8'b0000_1011, FLEN, 1'b1);
`endif
    idle(1, 1'b1);
    checkOutput("basic_valid", int'(p_valid_m), 1);
    checkOutput("basic_msb", int'(p_data_m), 'hB);
    checkOutput("basic_lsb", int'(p_data_l), 'hD);
`ifdef SIPO_PARITY_EN
    checkOutput("parity_ok", int'(p_perr_m), 0);
`endif
    idle(1, 1'b1);
    checkOutput("basic_valid_one_cycle", int'(p_valid_m), 0);

`ifdef SIPO_PARITY_EN
    // Bad parity bit
    sendSeq(8'b0001_0110, FLEN, 1'b1);
    idle(1, 1'b1);
    checkOutput("parity_bad_data", int'(p_data_m), 'hB);
    checkOutput("parity_bad_flag", int'(p_perr_m), 1);
    idle(1, 1'b1);
`endif

    // Back-pressure: two frames minus one bit with p_ready low
    sendWord(4'h3, 1'b0);
    sendSeq(8'b0000_0110, FLEN - 1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, acc);
      checkOutput("bp_stall", int'(acc), 0);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, acc);
    checkOutput("bp_release", int'(acc), 1);
    idle(1, 1'b0);
    checkOutput("bp_word2_valid", int'(p_valid_m), 1);
    idle(2, 1'b1);

    // Back-to-back words
    seen_msb.delete();
    sendWord(4'hA, 1'b1);
    sendWord(4'h5, 1'b1);
    sendWord(4'hF, 1'b1);
    idle(2, 1'b1);
    checkOutput("b2b_count", seen_msb.size(), 3);
    if (seen_msb.size() == 3) begin
      checkOutput("b2b_w0", int'(seen_msb[0]), 'hA);
      checkOutput("b2b_w1", int'(seen_msb[1]), 'h5);
      checkOutput("b2b_w2", int'(seen_msb[2]), 'hF);
    end

    // Flush with a valid bit in the same cycle
    sendSeq(8'b0000_0011, 2, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, acc);
    checkOutput("flush_discard", int'(acc), 0);
    sendWord(4'b0110, 1'b1);
    idle(1, 1'b1);
    checkOutput("flush_word_msb", int'(p_data_m), 'h6);
    checkOutput("flush_word_lsb", int'(p_data_l), 'h6);
    idle(1, 1'b1);

    // Asynchronous reset with a held word and a partial word
    sendWord(4'h9, 1'b0);
    sendSeq(8'b0000_0010, 2, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_valid_msb", int'(p_valid_m), 0);
    checkOutput("async_rst_data_msb", int'(p_data_m), 0);
    checkOutput("async_rst_valid_lsb", int'(p_valid_l), 0);
    checkOutput("async_rst_data_lsb", int'(p_data_l), 0);
    clearModel();
    p_ready = 1'b0;
    flush   = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sendWord(4'hC, 1'b1);
    idle(1, 1'b1);
    checkOutput("post_rst_word", int'(p_data_m), 'hC);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, acc);
    end
    idle(2 * FLEN, 1'b1);
    checkOutput("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Serial-in/parallel-out deserializer sitting directly upstream of the parallel-in/parallel-out register stage.
- Assembles WIDTH serial bits into one word and holds it in an output register until the downstream stage accepts it.
- Serial side and parallel side both use valid/ready handshakes. Back-pressure from the parallel side stalls the serial side.

Parameters:
- WIDTH, 4, parallel word width (>=2); matches the 4-bit downstream register by default.
- MSB_FIRST, 1, 1: first serial bit lands in p_data[WIDTH-1]; 0: first bit lands in p_data[0].

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous discard of the partially assembled word
- s_data  in  1  serial data bit
- s_valid  in  1  s_data valid
- s_ready  out  1  deserializer can accept a bit this cycle
- p_data  out  WIDTH  assembled word
- p_valid  out  1  p_data holds an unconsumed word
- p_ready  in  1  downstream accepts p_data this cycle

Behaviour:
- Reset (rst=0, asynchronous): bit count=0, shift reg=0, p_data=0, p_valid=0, s_ready=1 once rst released. Reset mid-word discards the partial word and any held word.
- Bit accept: s_valid && s_ready. The bit shifts in toward the MSB (MSB_FIRST=1) or the LSB (MSB_FIRST=0). The count increments, modulo WIDTH.
- out_free = !p_valid || p_ready.
- s_ready = (count != WIDTH-1) || out_free. Only the final bit of a word can stall.
- Final bit accepted (count==WIDTH-1):
  - The full word, including this bit, loads into p_data the same edge.
  - p_valid=1 from the next cycle (latency 1 clk after the last bit).
  - The count wraps to 0.
- Parallel handshake:
  - p_valid && p_ready clears p_valid the next cycle, unless a new word loads on the same edge. In that case p_valid stays 1 and p_data updates. There are no bubbles, so sustained throughput is 1 word per WIDTH cycles.
  - p_data is stable while p_valid && !p_ready.
- Accepted bits are never dropped or duplicated; there is no overflow path.
- flush=1:
  - Count → 0 and the shift reg clears next edge.
  - An s_valid bit in the same cycle is discarded (flush wins), and s_ready is forced to 0 that cycle.
  - flush does not affect p_data/p_valid; a held word remains deliverable.
- s_valid low mid-word: the partial word is retained indefinitely.
- p_ready while p_valid=0: ignored.

Optional Feature:
- Macro SIPO_PARITY_EN.
- Defined:
  - Each frame is WIDTH data bits followed by one even-parity bit, and the count runs 0..WIDTH.
  - The parity bit is not stored in p_data.
  - An extra output p_perr (1 bit) loads with p_data: 1 when XOR(data bits, parity bit)=1. p_perr resets to 0.
  - The stall rule applies to the parity bit (the frame's last bit).
  - flush also clears the running parity.
- Undefined: no p_perr port; frames are exactly WIDTH bits.

Decomposition:
- Package sipo_pkg:
  - constant CNT_W = $clog2(WIDTH+1)
  - localparam defaults for WIDTH/MSB_FIRST
  - typedef for the count type
  - frame-length constant (WIDTH, or WIDTH+1 under SIPO_PARITY_EN)
- One sub-module: sipo_shift_core. It holds the shift register, bit counter and running parity, and outputs word_done and the assembled word. The top level adds the output holding register and the handshake logic.

Test Plan:
- Basic word, MSB_FIRST=1, p_ready=1: serial bits 1,0,1,1 on 4 consecutive cycles → p_data=4'b1011, p_valid=1 exactly 1 clk after the 4th accept, and for 1 cycle.
- LSB order, MSB_FIRST=0: bits 1,0,1,1 → p_data=4'b1101.
- Back-pressure, p_ready=0: stream 8 bits.
  - Word 1 is held.
  - s_ready drops on the 8th bit (count=3 with p_valid=1).
  - Raising p_ready → word 1 consumed, 8th bit accepted the same cycle, word 2 valid next cycle.
  - No bit lost.
- Back-to-back, continuous valid/ready for 3 words (0xA,0x5,0xF): p_valid never drops between words; p_data sequence A,5,F.
- Flush/reset:
  - 2 bits in, then flush with s_valid=1 → that bit is discarded. The next 4 bits 0,1,1,0 give p_data=4'b0110.
  - Separately, rst=0 asserted mid-word asynchronously → p_valid=0, p_data=0 immediately.
- SIPO_PARITY_EN: bits 1,0,1,1 plus parity 1 → p_data=4'b1011, p_perr=0. Parity 0 → p_perr=1.
